// File: rtl/div_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_hilo_ctrl_if
//  Description : Connection between the HI/LO divide controller and the
//                unsigned 32-cycle divider core.
//                master : controller side (drives start and operands)
//                slave  : core side (drives busy, done and results)
//  Signals     : core_start     1-cycle launch pulse
//                core_dividend  unsigned dividend
//                core_divisor   unsigned divisor
//                core_busy      core is iterating
//                core_over      1-cycle done pulse
//                core_q/core_r  quotient/remainder, valid with core_over
//  Revision    : 1.0  initial release
// ============================================================================
interface div_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             core_start;
    logic [WIDTH-1:0] core_dividend;
    logic [WIDTH-1:0] core_divisor;
    logic             core_busy;
    logic             core_over;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;

    modport master (
        output core_start,
        output core_dividend,
        output core_divisor,
        input  core_busy,
        input  core_over,
        input  core_q,
        input  core_r
    );

    modport slave (
        input  core_start,
        input  core_dividend,
        input  core_divisor,
        output core_busy,
        output core_over,
        output core_q,
        output core_r
    );
endinterface
`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_hilo_ctrl
//  Description : Issue/writeback stage around the unsigned 32-cycle divider
//                core. Decodes DIV/DIVU, converts signed operands to
//                magnitudes, launches the core, stalls the pipeline while it
//                runs, sign-corrects quotient/remainder and writes LO/HI.
//                Also owns HI/LO for MTHI/MTLO.
//  Ports       : clock, reset        rising-edge clock, async active-high reset
//                op_div, op_divu     divide ops in execute (held while stall)
//                rs_data, rt_data    dividend / divisor
//                mthi, mtlo, wdata   direct HI/LO writes
//                stall               pipeline freeze (combinational)
//                hi, lo              HI/LO registers
//                timeout_err         sticky watchdog flag
//                core                divider core connection (master modport)
//                div_zero_exc        1-cycle divide-by-zero trap pulse
//                                    (only when DIV_ZERO_TRAP_EN is defined)
//  Config      : DIV_ZERO_TRAP_EN  undefined: x/0 bypasses the core and
//                                  writes LO=all ones, HI=rs_data.
//                                  defined: x/0 raises div_zero_exc instead.
//  Revision    : 1.0  initial release
// ============================================================================
module div_hilo_ctrl #(
    parameter int WIDTH    = 32,
    parameter int WAIT_MAX = 40
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             op_div,
    input  wire logic             op_divu,
    input  wire logic [WIDTH-1:0] rs_data,
    input  wire logic [WIDTH-1:0] rt_data,
    input  wire logic             mthi,
    input  wire logic             mtlo,
    input  wire logic [WIDTH-1:0] wdata,
    output logic                  stall,
    output logic      [WIDTH-1:0] hi,
    output logic      [WIDTH-1:0] lo,
    output logic                  timeout_err,
`ifdef DIV_ZERO_TRAP_EN
    output logic                  div_zero_exc,
`endif
    div_hilo_ctrl_if.master       core
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FIX    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_issue;
    logic             w_div_zero;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_abort;
    logic             w_stall;
    logic             w_start;

    // DIV wins when both op strobes are raised together.
    assign w_issue    = (r_state == S_IDLE) && (op_div || op_divu);
    assign w_div_zero = (rt_data == '0);
    assign w_neg_a    = op_div && rs_data[WIDTH-1];
    assign w_neg_b    = op_div && rt_data[WIDTH-1];

    // Watchdog expires on the WAIT_MAX-th WAIT cycle without a done pulse.
    assign w_abort    = (r_state == S_WAIT) && !core.core_over &&
                        (r_wait_cnt == c_cnt_last);

    assign stall              = w_stall;
    assign core.core_start    = w_start;
    assign core.core_dividend = r_dividend;
    assign core.core_divisor  = r_divisor;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, stall and core start
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
`ifdef DIV_ZERO_TRAP_EN
                    // A trapping divide retires immediately without a stall.
                    if (!w_div_zero) begin
                        w_stall = 1'b1;
                        w_next  = S_LAUNCH;
                    end
`else
                    // A zero divisor skips the core and goes straight to
                    // writeback with the fixed result already latched.
                    w_stall = 1'b1;
                    w_next  = w_div_zero ? S_FIX : S_LAUNCH;
`endif
                end
            end
            S_LAUNCH: begin
                w_stall = 1'b1;
                // The core's done flag has always cleared by now; the gate
                // just makes start/over overlap structurally impossible.
                w_start = !core.core_over;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (core.core_over) begin
                    w_stall = 1'b1;
                    w_next  = S_FIX;
                end else if (w_abort) begin
                    // Release the pipeline in the abort cycle so the CPU
                    // retires the divide instead of re-issuing it.
                    w_next  = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_FIX: begin
                // Stall is low here: the CPU advances on the same edge that
                // writes HI/LO, so the next IDLE cycle sees a new instruction.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operands, captured result, watchdog and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sign_q     <= 1'b0;
            r_sign_r     <= 1'b0;
            r_q          <= '0;
            r_r          <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_wait_cnt   <= '0;
            hi           <= '0;
            lo           <= '0;
            timeout_err  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_exc <= 1'b0;
`endif
        end else begin
`ifdef DIV_ZERO_TRAP_EN
            div_zero_exc <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        if (w_div_zero) begin
`ifdef DIV_ZERO_TRAP_EN
                            div_zero_exc <= 1'b1;
`else
                            // Raw result, no sign correction applied.
                            r_sign_q <= 1'b0;
                            r_sign_r <= 1'b0;
                            r_q      <= '1;
                            r_r      <= rs_data;
`endif
                        end else begin
                            r_sign_q   <= w_neg_a ^ w_neg_b;
                            r_sign_r   <= w_neg_a;
                            // Negating the most negative value yields itself,
                            // which is the correct magnitude read unsigned.
                            r_dividend <= w_neg_a ? (~rs_data + 1'b1) : rs_data;
                            r_divisor  <= w_neg_b ? (~rt_data + 1'b1) : rt_data;
                        end
                    end else begin
                        if (mthi) begin
                            hi <= wdata;
                        end
                        if (mtlo) begin
                            lo <= wdata;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (core.core_over) begin
                        r_q <= core.core_q;
                        r_r <= core.core_r;
                    end else if (w_abort) begin
                        timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    lo <= r_sign_q ? (~r_q + 1'b1) : r_q;
                    hi <= r_sign_r ? (~r_r + 1'b1) : r_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_hilo_ctrl
//  Description : Directed self-checking bench for div_hilo_ctrl with a
//                behavioural 32-cycle divider core stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_hilo_ctrl;

    localparam int WIDTH    = 32;
    localparam int WAIT_MAX = 40;
    localparam int BOUND    = 200;

    logic             clock;
    logic             reset;
    logic             op_div;
    logic             op_divu;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             timeout_err;
`ifdef DIV_ZERO_TRAP_EN
    logic             div_zero_exc;
`endif

    int checks = 0;
    int errors = 0;

    div_hilo_ctrl_if #(.WIDTH(WIDTH)) core_if ();

    div_hilo_ctrl #(
        .WIDTH    (WIDTH),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .op_div       (op_div),
        .op_divu      (op_divu),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .mthi         (mthi),
        .mtlo         (mtlo),
        .wdata        (wdata),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .timeout_err  (timeout_err),
`ifdef DIV_ZERO_TRAP_EN
        .div_zero_exc (div_zero_exc),
`endif
        .core         (core_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- divider core stub ----------------
    logic [5:0]       m_cnt;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    bit               core_dead = 1'b0;

    assign core_if.core_busy = (m_cnt != 6'd0);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt            <= 6'd0;
            m_a              <= '0;
            m_b              <= '0;
            core_if.core_over <= 1'b0;
            core_if.core_q   <= '0;
            core_if.core_r   <= '0;
        end else begin
            core_if.core_over <= 1'b0;
            if (core_if.core_start) begin
                m_a   <= core_if.core_dividend;
                m_b   <= core_if.core_divisor;
                m_cnt <= 6'd32;
            end else if (core_if.core_busy) begin
                m_cnt <= m_cnt - 6'd1;
                if (m_cnt == 6'd1 && !core_dead) begin
                    core_if.core_over <= 1'b1;
                    core_if.core_q    <= m_a / m_b;
                    core_if.core_r    <= m_a % m_b;
                end
            end
        end
    end

    // Cycle index of every core_start pulse.
    int cyc = 0;
    int starts[$];
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (core_if.core_start) starts.push_back(cyc);
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: put an instruction in execute.
    task automatic drive_op(input logic d, input logic du,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_div  = d;
        op_divu = du;
        rs_data = a;
        rt_data = b;
    endtask

    // Count stall cycles and start pulses until stall drops, then step past
    // that edge and return at posedge+1.
    task automatic wait_done(output int n_stall, output int n_start);
        int n;
        n_stall = 0;
        n_start = 0;
        n       = 0;
        forever begin
            @(negedge clock);
            if (core_if.core_start) n_start++;
            if (!stall) break;
            n_stall++;
            n++;
            if (n > BOUND) begin
                checks++;
                errors++;
                $display("FAIL wait_bound stall still high after %0d cycles", n);
                break;
            end
            @(posedge clock);
            #1;
            mthi = 1'b0;
            mtlo = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    int ns, nst;

    initial begin
        reset   = 1'b1;
        op_div  = 1'b0;
        op_divu = 1'b0;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wdata   = '0;

        // ---- reset state ----
        repeat (2) @(negedge clock);
        check("rst_hi",        hi,                    32'h0);
        check("rst_lo",        lo,                    32'h0);
        check("rst_stall",     {31'b0, stall},        32'h0);
        check("rst_timeout",   {31'b0, timeout_err},  32'h0);
        check("rst_start",     {31'b0, core_if.core_start}, 32'h0);
        check("rst_dividend",  core_if.core_dividend, 32'h0);
        check("rst_divisor",   core_if.core_divisor,  32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // ---- MTHI + MTLO in the same cycle ----
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", hi, 32'hCAFE_0001);
        check("mt_both_lo", lo, 32'hCAFE_0001);

        // ---- DIVU 100/7 ----
        drive_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("divu100_stall", ns,  32'd35);
        check("divu100_start", nst, 32'd1);
        check("divu100_lo",    lo,  32'd14);
        check("divu100_hi",    hi,  32'd2);

        // ---- DIV -7/2 (MTHI on the issue cycle must be ignored) ----
        mthi = 1'b1; wdata = 32'h1234_5678;
        drive_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("divm7_lo",  lo, 32'hFFFF_FFFD);
        check("divm7_hi",  hi, 32'hFFFF_FFFF);
        check("divm7_mag", core_if.core_dividend, 32'd7);

        // ---- DIV 7/-2 ----
        drive_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("div7m2_lo",  lo, 32'hFFFF_FFFD);
        check("div7m2_hi",  hi, 32'd1);
        check("div7m2_mag", core_if.core_divisor, 32'd2);

        // ---- signed overflow ----
        drive_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("ovf_lo",       lo, 32'h8000_0000);
        check("ovf_hi",       hi, 32'h0);
        check("ovf_dividend", core_if.core_dividend, 32'h8000_0000);

        // ---- both op strobes: behaves as DIV ----
        drive_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("both_lo", lo, 32'hFFFF_FFFD);
        check("both_hi", hi, 32'hFFFF_FFFF);

        // ---- DIVU 5/0 ----
        drive_op(1'b0, 1'b1, 32'd5, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
        @(negedge clock);
        check("dz_stall", {31'b0, stall}, 32'h0);
        @(posedge clock); #1;
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("dz_exc", {31'b0, div_zero_exc}, 32'h1);
        check("dz_lo",  lo, 32'hFFFF_FFFD);
        check("dz_hi",  hi, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        check("dz_exc_clr", {31'b0, div_zero_exc}, 32'h0);
`else
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("dz_stall", ns,  32'd1);
        check("dz_start", nst, 32'd0);
        check("dz_lo",    lo,  32'hFFFF_FFFF);
        check("dz_hi",    hi,  32'd5);
`endif

        // ---- back-to-back DIVU 9/4 then 10/3 ----
        drive_op(1'b0, 1'b1, 32'd9, 32'd4);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b1, 32'd10, 32'd3);
        check("b2b1_lo", lo, 32'd2);
        check("b2b1_hi", hi, 32'd1);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b2_lo",    lo,  32'd3);
        check("b2b2_hi",    hi,  32'd1);
        check("b2b2_start", nst, 32'd1);
        check("b2b_gap_ok",
              {31'b0, (starts.size() >= 2) &&
                      (starts[starts.size()-1] - starts[starts.size()-2] >= 2)},
              32'h1);

        // ---- reset in the middle of a divide ----
        drive_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        #1;
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'h0);
        check("midrst_hi",    hi, 32'h0);
        check("midrst_lo",    lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // ---- watchdog abort with a core that never finishes ----
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_00AA;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b0;
        core_dead = 1'b1;
        drive_op(1'b0, 1'b1, 32'd9, 32'd4);
        wait_done(ns, nst);
        drive_op(1'b0, 1'b0, 32'h0, 32'h0);
        check("wd_start",   nst, 32'd1);
        check("wd_stall_rng",
              {31'b0, (ns >= WAIT_MAX) && (ns <= WAIT_MAX + 2)}, 32'h1);
        check("wd_timeout", {31'b0, timeout_err}, 32'h1);
        check("wd_hi",      hi, 32'h0000_00AA);
        check("wd_lo",      lo, 32'h0000_00AA);
        repeat (3) @(posedge clock);
        #1;
        check("wd_sticky",  {31'b0, timeout_err}, 32'h1);
        check("wd_idle",    {31'b0, stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
